fetch_pc_unit: RTL and testbench

- Fetch-stage front end that consumes the branch predictor's pc_select and IF/ID flush outputs.
- Owns the architectural PC register, the next-PC mux, the instruction-memory address, and the IF/ID pipeline register.
- Supplies the ID stage with PC, instruction and valid, and provides saturating redirect/mispredict counters for the lab report.

---
 rtl/fetch_pc_unit.sv | 97 +++++++++
 tb/tb_fetch_pc_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// Fetch-stage front end: PC register, next-PC mux, IF/ID register and
// saturating redirect/mispredict counters.
module fetch_pc_unit #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic [1:0]       pc_select_i,
    input  logic             Flush_IF_ID_i,
    input  logic [XLEN-1:0]  ID_target_i,
    input  logic [XLEN-1:0]  EX_target_i,
    input  logic [XLEN-1:0]  EX_fallthrough_i,
    input  logic [XLEN-1:0]  instr_i,
    output logic [XLEN-1:0]  imem_addr_o,
    output logic [XLEN-1:0]  IF_ID_pc_o,
    output logic [XLEN-1:0]  IF_ID_instr_o,
    output logic             IF_ID_valid_o,
    output logic [CNT_W-1:0] redirect_cnt_o,
    output logic [CNT_W-1:0] mispredict_cnt_o
);

    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_if_id_pc;
    logic [XLEN-1:0]  r_if_id_instr;
    logic             r_if_id_valid;
    logic [CNT_W-1:0] r_redirect_cnt;
    logic [CNT_W-1:0] r_mispredict_cnt;

    logic [XLEN-1:0]  w_next_pc;
    logic             w_redirect;
    logic             w_mispredict;

    assign w_mispredict = pc_select_i[1];
    assign w_redirect   = (pc_select_i == 2'b01) && !stall_i;

    // Mispredict recovery overrides stall: the stalled instruction is wrong-path.
    always_comb begin
        w_next_pc = r_pc;
        if (pc_select_i == 2'b11)
            w_next_pc = {EX_target_i[XLEN-1:2], 2'b00};
        else if (pc_select_i == 2'b10)
            w_next_pc = {EX_fallthrough_i[XLEN-1:2], 2'b00};
        else if (stall_i)
            w_next_pc = r_pc;
        else if (pc_select_i == 2'b01)
            w_next_pc = {ID_target_i[XLEN-1:2], 2'b00};
        else
            w_next_pc = r_pc + XLEN'(4);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_pc <= XLEN'(RESET_PC);
        else
            r_pc <= w_next_pc;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_if_id_pc    <= '0;
            r_if_id_instr <= '0;
            r_if_id_valid <= 1'b0;
        end else if (Flush_IF_ID_i) begin
            r_if_id_pc    <= '0;
            r_if_id_instr <= '0;
            r_if_id_valid <= 1'b0;
        end else if (!stall_i) begin
            r_if_id_pc    <= r_pc;
            r_if_id_instr <= instr_i;
            r_if_id_valid <= 1'b1;
        end
    end

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_redirect_cnt   <= '0;
            r_mispredict_cnt <= '0;
        end else begin
            if (w_redirect && (r_redirect_cnt != '1))
                r_redirect_cnt <= r_redirect_cnt + CNT_W'(1);
            if (w_mispredict && (r_mispredict_cnt != '1))
                r_mispredict_cnt <= r_mispredict_cnt + CNT_W'(1);
        end
    end

    assign imem_addr_o      = r_pc;
    assign IF_ID_pc_o       = r_if_id_pc;
    assign IF_ID_instr_o    = r_if_id_instr;
    assign IF_ID_valid_o    = r_if_id_valid;
    assign redirect_cnt_o   = r_redirect_cnt;
    assign mispredict_cnt_o = r_mispredict_cnt;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit; 2-bit counters make saturation reachable.
module tb_fetch_pc_unit;

    localparam int XLEN  = 32;
    localparam int CNT_W = 2;
    localparam logic [31:0] IMASK = 32'hA5A5_0000;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             stall_i;
    logic [1:0]       pc_select_i;
    logic             Flush_IF_ID_i;
    logic [XLEN-1:0]  ID_target_i;
    logic [XLEN-1:0]  EX_target_i;
    logic [XLEN-1:0]  EX_fallthrough_i;
    logic [XLEN-1:0]  instr_i;
    logic [XLEN-1:0]  imem_addr_o;
    logic [XLEN-1:0]  IF_ID_pc_o;
    logic [XLEN-1:0]  IF_ID_instr_o;
    logic             IF_ID_valid_o;
    logic [CNT_W-1:0] redirect_cnt_o;
    logic [CNT_W-1:0] mispredict_cnt_o;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk_i = ~clk_i;

    // Memory model: data is a fixed function of the address.
    assign instr_i = imem_addr_o ^ IMASK;

    fetch_pc_unit #(.XLEN(XLEN), .RESET_PC(32'h0), .CNT_W(CNT_W)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .stall_i          (stall_i),
        .pc_select_i      (pc_select_i),
        .Flush_IF_ID_i    (Flush_IF_ID_i),
        .ID_target_i      (ID_target_i),
        .EX_target_i      (EX_target_i),
        .EX_fallthrough_i (EX_fallthrough_i),
        .instr_i          (instr_i),
        .imem_addr_o      (imem_addr_o),
        .IF_ID_pc_o       (IF_ID_pc_o),
        .IF_ID_instr_o    (IF_ID_instr_o),
        .IF_ID_valid_o    (IF_ID_valid_o),
        .redirect_cnt_o   (redirect_cnt_o),
        .mispredict_cnt_o (mispredict_cnt_o)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [1:0] sel, input logic stall, input logic flush);
        pc_select_i   = sel;
        stall_i       = stall;
        Flush_IF_ID_i = flush;
    endtask

    task automatic check_if_id(input string tag, input logic [31:0] pc, input logic valid);
        check_val({tag, "_ifid_pc"}, IF_ID_pc_o, pc);
        check_val({tag, "_ifid_valid"}, {31'b0, IF_ID_valid_o}, {31'b0, valid});
        check_val({tag, "_ifid_instr"}, IF_ID_instr_o, valid ? (pc ^ IMASK) : 32'h0);
    endtask

    initial begin
        rst_i = 1'b1;
        drive(2'b00, 1'b0, 1'b0);
        ID_target_i = '0; EX_target_i = '0; EX_fallthrough_i = '0;
        step(); step();

        check_val("rst_pc", imem_addr_o, 32'h0);
        check_if_id("rst", 32'h0, 1'b0);
        check_val("rst_redir", {30'b0, redirect_cnt_o}, 32'd0);
        check_val("rst_mispr", {30'b0, mispredict_cnt_o}, 32'd0);

        rst_i = 1'b0;
        step();
        check_val("seq1_pc", imem_addr_o, 32'h4);
        check_if_id("seq1", 32'h0, 1'b1);
        step();
        check_val("seq2_pc", imem_addr_o, 32'h8);
        check_if_id("seq2", 32'h4, 1'b1);
        step();
        check_val("seq3_pc", imem_addr_o, 32'hC);
        check_if_id("seq3", 32'h8, 1'b1);

        // Predicted-taken redirect with flush.
        drive(2'b01, 1'b0, 1'b1); ID_target_i = 32'h40;
        step();
        check_val("redir_pc", imem_addr_o, 32'h40);
        check_if_id("redir", 32'h0, 1'b0);
        check_val("redir_cnt", {30'b0, redirect_cnt_o}, 32'd1);
        drive(2'b00, 1'b0, 1'b0);
        step();
        check_val("after_redir_pc", imem_addr_o, 32'h44);
        check_if_id("after_redir", 32'h40, 1'b1);

        // Mispredict taken while stalled.
        drive(2'b11, 1'b1, 1'b1); EX_target_i = 32'h100;
        step();
        check_val("mp11_pc", imem_addr_o, 32'h100);
        check_if_id("mp11", 32'h0, 1'b0);
        check_val("mp11_cnt", {30'b0, mispredict_cnt_o}, 32'd1);
        check_val("mp11_redir", {30'b0, redirect_cnt_o}, 32'd1);
        drive(2'b00, 1'b0, 1'b0);
        step();
        check_val("mp11_next_pc", imem_addr_o, 32'h104);
        check_if_id("mp11_next", 32'h100, 1'b1);

        // Mispredict not-taken restores fall-through.
        drive(2'b10, 1'b0, 1'b0); EX_fallthrough_i = 32'h1C;
        step();
        check_val("mp10_pc", imem_addr_o, 32'h1C);
        check_if_id("mp10", 32'h104, 1'b1);
        check_val("mp10_cnt", {30'b0, mispredict_cnt_o}, 32'd2);

        // Stall holds PC and IF/ID; 01 under stall is ignored.
        drive(2'b00, 1'b1, 1'b0);
        step();
        check_val("stall1_pc", imem_addr_o, 32'h1C);
        check_if_id("stall1", 32'h104, 1'b1);
        drive(2'b01, 1'b1, 1'b0); ID_target_i = 32'h80;
        step();
        check_val("stall2_pc", imem_addr_o, 32'h1C);
        check_if_id("stall2", 32'h104, 1'b1);
        check_val("stall2_redir", {30'b0, redirect_cnt_o}, 32'd1);
        drive(2'b00, 1'b0, 1'b0);
        step();
        check_val("unstall_pc", imem_addr_o, 32'h20);
        check_if_id("unstall", 32'h1C, 1'b1);

        // Alignment and wrap-around.
        drive(2'b01, 1'b0, 1'b0); ID_target_i = 32'hFFFF_FFFF;
        step();
        check_val("top_pc", imem_addr_o, 32'hFFFF_FFFC);
        check_val("top_redir", {30'b0, redirect_cnt_o}, 32'd2);
        drive(2'b00, 1'b0, 1'b0);
        step();
        check_val("wrap_pc", imem_addr_o, 32'h0);
        check_if_id("wrap", 32'hFFFF_FFFC, 1'b1);
        drive(2'b01, 1'b0, 1'b0); ID_target_i = 32'h43;
        step();
        check_val("align_pc", imem_addr_o, 32'h40);
        check_val("align_redir", {30'b0, redirect_cnt_o}, 32'd3);
        ID_target_i = 32'h10;
        step();
        check_val("sat_redir_pc", imem_addr_o, 32'h10);
        check_val("sat_redir", {30'b0, redirect_cnt_o}, 32'd3);

        // Mispredict counter saturation.
        drive(2'b11, 1'b0, 1'b1); EX_target_i = 32'h200;
        step();
        check_val("mp3_cnt", {30'b0, mispredict_cnt_o}, 32'd3);
        drive(2'b10, 1'b0, 1'b1); EX_fallthrough_i = 32'h300;
        step();
        check_val("mp4_pc", imem_addr_o, 32'h300);
        check_val("mp4_cnt", {30'b0, mispredict_cnt_o}, 32'd3);
        drive(2'b11, 1'b0, 1'b1); EX_target_i = 32'h402;
        step();
        check_val("mp5_pc", imem_addr_o, 32'h400);
        check_val("mp5_cnt", {30'b0, mispredict_cnt_o}, 32'd3);
        drive(2'b00, 1'b0, 1'b0);
        step();
        check_val("pre_rst_pc", imem_addr_o, 32'h404);
        check_if_id("pre_rst", 32'h400, 1'b1);

        // Asynchronous reset between clock edges.
        #2;
        rst_i = 1'b1;
        #1;
        check_val("arst_pc", imem_addr_o, 32'h0);
        check_if_id("arst", 32'h0, 1'b0);
        check_val("arst_redir", {30'b0, redirect_cnt_o}, 32'd0);
        check_val("arst_mispr", {30'b0, mispredict_cnt_o}, 32'd0);
        step();
        rst_i = 1'b0;
        step();
        check_val("post_rst_pc", imem_addr_o, 32'h4);
        check_if_id("post_rst", 32'h0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
